// File: rtl/pool2x2_stream_if.sv
// Stream bundle for pool2x2_stream: pixel input handshake and pooled-output handshake.
// The master side feeds pixels and accepts results; the slave side is the pooling block.
interface pool2x2_stream_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_max;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_last
    );
endinterface

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-ordered feature map.
// Define POOL_RELU_EN to clamp negative window maxima to 0 (fused ReLU).
module pool2x2_stream #(
    parameter int COL_NUM = 8,
    parameter int ROW_NUM = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pool2x2_stream_if.slave pif
);
    localparam int CW = (COL_NUM > 2) ? $clog2(COL_NUM) : 1;
    localparam int RW = (ROW_NUM > 2) ? $clog2(ROW_NUM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic signed [7:0]      left_q, left_d;
    logic [COL_NUM-1:0][7:0] lbuf_q;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic signed [7:0]      out_max_q, out_max_d;

    logic                   in_xfer, out_xfer, win_load;
    logic signed [7:0]      top_l, top_r, win_max, pooled;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Input stalls only while a finished window is waiting for downstream.
    assign pif.in_ready = !(out_valid_q && !pif.out_ready);
    assign in_xfer      = pif.in_valid && pif.in_ready;
    assign out_xfer     = out_valid_q && pif.out_ready;
    assign win_load     = in_xfer && row_q[0] && col_q[0];

    assign top_l   = $signed(lbuf_q[col_q - CW'(1)]);
    assign top_r   = $signed(lbuf_q[col_q]);
    assign win_max = smax(smax(top_l, top_r), smax(left_q, pif.in_data));

`ifdef POOL_RELU_EN
    assign pooled = win_max[7] ? 8'sd0 : win_max;
`else
    assign pooled = win_max;
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        left_d = left_q;
        if (in_xfer && row_q[0] && !col_q[0])
            left_d = pif.in_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_last_d  = out_last_q;
        if (win_load) begin
            out_valid_d = 1'b1;
            out_max_d   = pooled;
            out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            left_q      <= left_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_last_q  <= out_last_d;
        end
    end

    // Top row of each window pair; always rewritten on an even row before being read.
    always_ff @(posedge clk) begin
        if (in_xfer && !row_q[0])
            lbuf_q[col_q] <= pif.in_data;
    end

    assign pif.out_valid = out_valid_q;
    assign pif.out_max   = out_max_q;
    assign pif.out_last  = out_last_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: a 4x2 and an 8x8 instance driven by one stimulus set,
// checked against a plain array max-pool model plus literal expectations.
module tb_pool2x2_stream;
    typedef struct { int mx; bit last; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic sel = 1'b0;
    logic signed [7:0] in_data = '0;

    int nvec = 0, nerr = 0, nout = 0, nlast = 0;
    int ncol = 4, nrow = 2;
    int stall_left = 0, stall_seen = 0, cyc = 0;
    exp_t expq[$];
    int frame[2][64];
    bit hold_q = 1'b0;
    logic signed [7:0] prev_max = '0;
    logic prev_last = 1'b0;

    always #5 clk = ~clk;

    pool2x2_stream_if ifs();
    pool2x2_stream_if ifb();

    assign ifs.in_valid  = in_valid & ~sel;
    assign ifs.in_data   = in_data;
    assign ifs.out_ready = sel ? 1'b1 : out_ready;
    assign ifb.in_valid  = in_valid & sel;
    assign ifb.in_data   = in_data;
    assign ifb.out_ready = sel ? out_ready : 1'b1;

    pool2x2_stream #(.COL_NUM(4), .ROW_NUM(2)) dut_s (.clk(clk), .rst_n(rst_n), .pif(ifs));
    pool2x2_stream #(.COL_NUM(8), .ROW_NUM(8)) dut_b (.clk(clk), .rst_n(rst_n), .pif(ifb));

    logic cur_in_ready, cur_out_valid, cur_out_ready, cur_out_last;
    logic signed [7:0] cur_out_max;
    assign cur_in_ready  = sel ? ifb.in_ready  : ifs.in_ready;
    assign cur_out_valid = sel ? ifb.out_valid : ifs.out_valid;
    assign cur_out_ready = sel ? ifb.out_ready : ifs.out_ready;
    assign cur_out_last  = sel ? ifb.out_last  : ifs.out_last;
    assign cur_out_max   = sel ? ifb.out_max   : ifs.out_max;

    task automatic chk(input string nm, input int act, input int expv);
        nvec++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: plain 2x2 max-pool over the stored frame, windows in raster order.
    task automatic build_exp(input int f);
        for (int wr = 0; wr < nrow / 2; wr++) begin
            for (int wc = 0; wc < ncol / 2; wc++) begin
                int b, m;
                exp_t e;
                b = 2 * wr * ncol + 2 * wc;
                m = imax(imax(frame[f][b], frame[f][b + 1]),
                         imax(frame[f][b + ncol], frame[f][b + ncol + 1]));
`ifdef POOL_RELU_EN
                if (m < 0) m = 0;
`endif
                e.mx = m;
                e.last = (wr == nrow / 2 - 1) && (wc == ncol / 2 - 1);
                expq.push_back(e);
            end
        end
    endtask

    // Called right after a falling edge; returns right after a later falling edge.
    task automatic send_pix(input int d, input int vpct, input int rpct);
        bit acc = 1'b0;
        int guard = 0;
        while (!acc) begin
            in_valid = ($urandom_range(99) < vpct);
            in_data  = in_valid ? 8'(d) : 8'($urandom_range(255));
            if (stall_left > 0 && cur_out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < rpct);
            end
            #4;
            if (!out_ready && in_valid && !cur_in_ready) stall_seen++;
            acc = in_valid && cur_in_ready;
            cyc++;
            @(negedge clk);
            guard++;
            if (!acc && guard > 300) begin
                chk("send_timeout", guard, 0);
                acc = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int f, input int vpct, input int rpct);
        for (int i = 0; i < ncol * nrow; i++) send_pix(frame[f][i], vpct, rpct);
    endtask

    task automatic drain();
        int g = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (expq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", expq.size(), 0);
        chk("drain_idle", int'(cur_out_valid), 0);
    endtask

    // Per-cycle compare: handshake rule, stall stability, and transfers vs model.
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            chk("in_ready_rule", int'(cur_in_ready), int'(!(cur_out_valid && !cur_out_ready)));
            if (hold_q) begin
                chk("hold_valid", int'(cur_out_valid), 1);
                chk("hold_max", int'(cur_out_max), int'(prev_max));
                chk("hold_last", int'(cur_out_last), int'(prev_last));
            end
            if (cur_out_valid && cur_out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_out", int'(cur_out_max), 999);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("out_max", int'(cur_out_max), e.mx);
                    chk("out_last", int'(cur_out_last), int'(e.last));
                end
                nout++;
                if (cur_out_last) nlast++;
            end
            hold_q    = cur_out_valid && !cur_out_ready;
            prev_max  = cur_out_max;
            prev_last = cur_out_last;
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit_a[8] = '{1, 2, 3, 4, 5, -6, 7, 8};
        int lit_b[8] = '{-8, -3, -1, -2, -5, -128, -7, -4};
        int o0, l0, c0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("rst_valid_s", int'(ifs.out_valid), 0);
        chk("rst_max_s", int'(ifs.out_max), 0);
        chk("rst_last_s", int'(ifs.out_last), 0);
        chk("rst_ready_s", int'(ifs.in_ready), 1);
        chk("rst_valid_b", int'(ifb.out_valid), 0);
        chk("rst_ready_b", int'(ifb.in_ready), 1);
        @(negedge clk);

        // 4x2 frame: windows {1,2,5,-6} -> 5 and {3,4,7,8} -> 8
        sel = 1'b0; ncol = 4; nrow = 2;
        for (int i = 0; i < 8; i++) frame[0][i] = lit_a[i];
        build_exp(0);
        chk("lit_a_w0", expq[0].mx, 5);
        chk("lit_a_w1", expq[1].mx, 8);
        chk("lit_a_last0", int'(expq[0].last), 0);
        chk("lit_a_last1", int'(expq[1].last), 1);
        o0 = nout; l0 = nlast;
        send_frame(0, 100, 100);
        drain();
        chk("a_outputs", nout - o0, 2);
        chk("a_lasts", nlast - l0, 1);

        // All-negative window
        for (int i = 0; i < 8; i++) frame[0][i] = lit_b[i];
        build_exp(0);
`ifdef POOL_RELU_EN
        chk("lit_b_w0", expq[0].mx, 0);
`else
        chk("lit_b_w0", expq[0].mx, -3);
        chk("lit_b_w1", expq[1].mx, -1);
`endif
        send_frame(0, 100, 100);
        drain();

        // 8x8 with a 5-cycle downstream stall at the first output
        sel = 1'b1; ncol = 8; nrow = 8;
        for (int i = 0; i < 64; i++) frame[0][i] = ((i * 37) % 256) - 128;
        build_exp(0);
        stall_left = 5; stall_seen = 0;
        send_frame(0, 100, 100);
        drain();
        chk("stall_cycles", stall_seen, 5);

        // Two frames back to back, continuous valid/ready
        for (int i = 0; i < 64; i++) frame[1][i] = 127 - ((i * 11) % 256);
        build_exp(0);
        build_exp(1);
        o0 = nout; l0 = nlast; c0 = cyc;
        send_frame(0, 100, 100);
        send_frame(1, 100, 100);
        drain();
        chk("b2b_cycles", cyc - c0, 128);
        chk("b2b_outputs", nout - o0, 32);
        chk("b2b_lasts", nlast - l0, 2);

        // Reset after 6 pixels, then a full new frame
        for (int i = 0; i < 6; i++) send_pix(frame[0][i], 100, 100);
        rst_n = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("rst_mid_valid", int'(cur_out_valid), 0);
            chk("rst_mid_ready", int'(cur_in_ready), 1);
            @(negedge clk);
        end
        expq.delete();
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) frame[1][i] = (i % 2 == 0) ? -(i + 1) : i * 2;
        build_exp(1);
        o0 = nout;
        send_frame(1, 100, 100);
        drain();
        chk("rst_outputs", nout - o0, 16);

        // Random valid gaps and random backpressure, full signed range
        for (int i = 0; i < 64; i++) frame[0][i] = int'($urandom_range(255)) - 128;
        frame[0][0] = -128; frame[0][1] = 127;
        build_exp(0);
        o0 = nout; l0 = nlast;
        send_frame(0, 50, 70);
        drain();
        chk("rnd_outputs", nout - o0, 16);
        chk("rnd_lasts", nlast - l0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
